// File: rtl/medyan_havuzu_if.sv
// medyan_havuzu_if
// ----------------
// Window-in / result-out bus of the rank-filter pool.
//
// Handshake rule (both directions): a transfer happens on a rising clock
// edge where the producer's *_gecerli and the consumer's *_hazir are both 1.
// A producer holds its payload stable while *_gecerli=1 and *_hazir=0; the
// consumer may raise or drop *_hazir at any time.
//
// Signals (direction as seen by the pool, i.e. the slave modport):
//   giris_gecerli_i  in   window valid
//   giris_hazir_o    out  pool can take a window this cycle
//   pencere_i        in   PENCERE*PIXEL_BIT window, element k at [k*PIXEL_BIT +: PIXEL_BIT]
//   mod_i            in   00 median, 01 min, 10 max, 11 median
//   cikis_gecerli_o  out  result valid
//   cikis_hazir_i    in   downstream takes the result
//   pixel_o          out  result pixel, 0 while cikis_gecerli_o=0
interface medyan_havuzu_if #(
    parameter int PIXEL_BIT = 8,
    parameter int PENCERE   = 9
);
    logic                           giris_gecerli_i;
    logic                           giris_hazir_o;
    logic [PENCERE*PIXEL_BIT-1:0]   pencere_i;
    logic [1:0]                     mod_i;
    logic                           cikis_gecerli_o;
    logic                           cikis_hazir_i;
    logic [PIXEL_BIT-1:0]           pixel_o;

    modport slave (
        input  giris_gecerli_i, pencere_i, mod_i, cikis_hazir_i,
        output giris_hazir_o, cikis_gecerli_o, pixel_o
    );

    modport master (
        output giris_gecerli_i, pencere_i, mod_i, cikis_hazir_i,
        input  giris_hazir_o, cikis_gecerli_o, pixel_o
    );
endinterface

// File: rtl/medyan_havuzu.sv
// medyan_havuzu
// -------------
// Pool of SERIT rank-filter lanes. Each lane takes one PENCERE-element
// window and, one element per clock, finds the element whose rank equals
// the target rank (median, min or max). Windows are handed to lanes
// round-robin and results leave in the same round-robin order, so output
// order always equals acceptance order.
//
// Ports:
//   clk_i        clock, rising edge
//   rstn_i       asynchronous active-low reset
//   temizle_i    synchronous flush, same end state as reset
//   bus          window/result handshake bus (slave side)
//   doluluk_o    number of lanes that are not empty
//   durum_dbg_o  per-lane state, lane s at [2*s +: 2] (0 empty, 1 computing, 2 result held)
module medyan_havuzu #(
    parameter int PIXEL_BIT = 8,
    parameter int PENCERE   = 9,
    parameter int SERIT     = 10
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       temizle_i,
    medyan_havuzu_if.slave             bus,
    output logic [$clog2(SERIT+1)-1:0] doluluk_o,
    output logic [2*SERIT-1:0]         durum_dbg_o
);
    localparam int PW = $clog2(SERIT);
    localparam int KW = $clog2(PENCERE);
    localparam int DW = $clog2(SERIT+1);
    localparam int WW = PENCERE*PIXEL_BIT;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        HESAP = 2'd1,
        DOLU  = 2'd2
    } durum_e;

    durum_e               durum_q   [SERIT];
    durum_e               durum_d   [SERIT];
    logic [WW-1:0]        pencere_q [SERIT];
    logic [WW-1:0]        pencere_d [SERIT];
    logic [KW-1:0]        hedef_q   [SERIT];
    logic [KW-1:0]        hedef_d   [SERIT];
    logic [KW-1:0]        k_q       [SERIT];
    logic [KW-1:0]        k_d       [SERIT];
    logic [PIXEL_BIT-1:0] sonuc_q   [SERIT];
    logic [PIXEL_BIT-1:0] sonuc_d   [SERIT];
    logic                 bulundu_q [SERIT];
    logic                 bulundu_d [SERIT];
    logic [PW-1:0]        giris_ptr_q, giris_ptr_d;
    logic [PW-1:0]        cikis_ptr_q, cikis_ptr_d;
    logic [DW-1:0]        doluluk_q, doluluk_d;

    logic [PIXEL_BIT-1:0] eleman_w   [SERIT];
    logic                 eslesme_w  [SERIT];
    logic [KW-1:0]        hedef_yeni;
    logic                 giris_hazir, cikis_gecerli, kabul, cekis;

    // Rank of the current element k in each lane. Equal values are ordered
    // by position (earlier index ranks lower), which makes every rank unique.
    always_comb begin
        int unsigned sayac;
        logic [PIXEL_BIT-1:0] xk, xj;
        sayac = 0;
        xk    = '0;
        xj    = '0;
        for (int s = 0; s < SERIT; s++) begin
            xk    = pencere_q[s][int'(k_q[s])*PIXEL_BIT +: PIXEL_BIT];
            sayac = 0;
            for (int j = 0; j < PENCERE; j++) begin
                xj = pencere_q[s][j*PIXEL_BIT +: PIXEL_BIT];
                if (xj < xk) begin
                    sayac = sayac + 1;
                end else if ((xj == xk) && (j < int'(k_q[s]))) begin
                    sayac = sayac + 1;
                end
            end
            eleman_w[s]  = xk;
            eslesme_w[s] = (KW'(sayac) == hedef_q[s]);
        end
    end

    always_comb begin
        case (bus.mod_i)
            2'b01:   hedef_yeni = '0;
            2'b10:   hedef_yeni = KW'(PENCERE-1);
            default: hedef_yeni = KW'((PENCERE-1)/2);
        endcase
    end

    // The second term lets the head lane be popped and reloaded on the same
    // edge, which is what keeps a full pool streaming at one window/cycle.
    assign cikis_gecerli = (durum_q[cikis_ptr_q] == DOLU) && !temizle_i;
    assign giris_hazir   = !temizle_i &&
                           ((durum_q[giris_ptr_q] == BOS) ||
                            ((durum_q[giris_ptr_q] == DOLU) &&
                             (giris_ptr_q == cikis_ptr_q) && bus.cikis_hazir_i));
    assign kabul = bus.giris_gecerli_i && giris_hazir;
    assign cekis = cikis_gecerli && bus.cikis_hazir_i;

    assign bus.giris_hazir_o   = giris_hazir;
    assign bus.cikis_gecerli_o = cikis_gecerli;
    assign bus.pixel_o         = cikis_gecerli ? sonuc_q[cikis_ptr_q] : '0;
    assign doluluk_o           = doluluk_q;

    always_comb begin
        giris_ptr_d = giris_ptr_q;
        cikis_ptr_d = cikis_ptr_q;
        doluluk_d   = doluluk_q;
        for (int s = 0; s < SERIT; s++) begin
            durum_d[s]   = durum_q[s];
            pencere_d[s] = pencere_q[s];
            hedef_d[s]   = hedef_q[s];
            k_d[s]       = k_q[s];
            sonuc_d[s]   = sonuc_q[s];
            bulundu_d[s] = bulundu_q[s];
        end

        for (int s = 0; s < SERIT; s++) begin
            if (durum_q[s] == HESAP) begin
                if (eslesme_w[s]) begin
                    sonuc_d[s]   = eleman_w[s];
                    bulundu_d[s] = 1'b1;
                end
                if (k_q[s] == KW'(PENCERE-1)) begin
                    durum_d[s] = DOLU;
                end else begin
                    k_d[s] = k_q[s] + 1'b1;
                end
            end
            if (cekis && (PW'(s) == cikis_ptr_q)) begin
                durum_d[s] = BOS;
            end
            // A load overrides a same-edge pop of the same lane (DOLU -> HESAP).
            if (kabul && (PW'(s) == giris_ptr_q)) begin
                durum_d[s]   = HESAP;
                pencere_d[s] = bus.pencere_i;
                hedef_d[s]   = hedef_yeni;
                k_d[s]       = '0;
                bulundu_d[s] = 1'b0;
            end
        end

        if (kabul) begin
            giris_ptr_d = (giris_ptr_q == PW'(SERIT-1)) ? '0 : giris_ptr_q + 1'b1;
        end
        if (cekis) begin
            cikis_ptr_d = (cikis_ptr_q == PW'(SERIT-1)) ? '0 : cikis_ptr_q + 1'b1;
        end
        case ({kabul, cekis})
            2'b10:   doluluk_d = doluluk_q + 1'b1;
            2'b01:   doluluk_d = doluluk_q - 1'b1;
            default: doluluk_d = doluluk_q;
        endcase

        if (temizle_i) begin
            giris_ptr_d = '0;
            cikis_ptr_d = '0;
            doluluk_d   = '0;
            for (int s = 0; s < SERIT; s++) begin
                durum_d[s]   = BOS;
                pencere_d[s] = '0;
                hedef_d[s]   = '0;
                k_d[s]       = '0;
                sonuc_d[s]   = '0;
                bulundu_d[s] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            giris_ptr_q <= '0;
            cikis_ptr_q <= '0;
            doluluk_q   <= '0;
            for (int s = 0; s < SERIT; s++) begin
                durum_q[s]   <= BOS;
                pencere_q[s] <= '0;
                hedef_q[s]   <= '0;
                k_q[s]       <= '0;
                sonuc_q[s]   <= '0;
                bulundu_q[s] <= 1'b0;
            end
        end else begin
            giris_ptr_q <= giris_ptr_d;
            cikis_ptr_q <= cikis_ptr_d;
            doluluk_q   <= doluluk_d;
            for (int s = 0; s < SERIT; s++) begin
                durum_q[s]   <= durum_d[s];
                pencere_q[s] <= pencere_d[s];
                hedef_q[s]   <= hedef_d[s];
                k_q[s]       <= k_d[s];
                sonuc_q[s]   <= sonuc_d[s];
                bulundu_q[s] <= bulundu_d[s];
            end
        end
    end

    for (genvar g = 0; g < SERIT; g++) begin : g_serit
        assign durum_dbg_o[2*g +: 2] = durum_q[g];

        // A lane latches exactly once per window: never a second match, and
        // the last element cannot pass without a match having occurred.
        a_tek_eslesme: assert property (@(posedge clk_i) disable iff (!rstn_i || temizle_i)
            ((durum_q[g] == HESAP) && eslesme_w[g]) |-> !bulundu_q[g]);
        a_eslesme_var: assert property (@(posedge clk_i) disable iff (!rstn_i || temizle_i)
            ((durum_q[g] == HESAP) && (k_q[g] == KW'(PENCERE-1))) |-> (bulundu_q[g] || eslesme_w[g]));
    end
endmodule

// File: tb/tb_medyan_havuzu.sv
module tb_medyan_havuzu;
    typedef logic [7:0] pen_t [9];

    logic       clk = 1'b0;
    logic       rstn;
    logic       temizle;
    logic [3:0] dol_a;
    logic [2:0] dol_b;
    logic [19:0] dbg_a;
    logic [9:0]  dbg_b;

    int n_check = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int son_kabul = 0;

    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    medyan_havuzu_if #(.PIXEL_BIT(8), .PENCERE(9)) if_a ();
    medyan_havuzu_if #(.PIXEL_BIT(8), .PENCERE(3)) if_b ();

    medyan_havuzu #(.PIXEL_BIT(8), .PENCERE(9), .SERIT(10)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .temizle_i(temizle), .bus(if_a),
        .doluluk_o(dol_a), .durum_dbg_o(dbg_a)
    );

    medyan_havuzu #(.PIXEL_BIT(8), .PENCERE(3), .SERIT(5)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .temizle_i(temizle), .bus(if_b),
        .doluluk_o(dol_b), .durum_dbg_o(dbg_b)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got cycle %0d, expected end of test", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $fatal(1, "timeout");
    end

    task automatic check(input bit ok, input string ad, input int got, input int exp);
        n_check++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", ad, got, exp, $time);
        end
    endtask

    // Reference: sort the window and pick the element at the target rank.
    function automatic logic [7:0] ref_model(input pen_t px, input int n, input logic [1:0] m);
        logic [7:0] a [9];
        logic [7:0] t;
        int hedef;
        for (int k = 0; k < 9; k++) a[k] = px[k];
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n - 1 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        if (m == 2'b01)      hedef = 0;
        else if (m == 2'b10) hedef = n - 1;
        else                 hedef = (n - 1) / 2;
        return a[hedef];
    endfunction

    task automatic adim();
        @(posedge clk);
        #1;
    endtask

    task automatic rastgele(output pen_t p);
        for (int k = 0; k < 9; k++) p[k] = 8'($urandom_range(0, 255));
    endtask

    // Drive one window until accepted; push the expected result at acceptance.
    task automatic push_win(input bit sec_b, input pen_t px, input logic [1:0] m, output int bekleme);
        logic [71:0] w;
        int n;
        bit bitti;
        n = sec_b ? 3 : 9;
        w = '0;
        for (int k = 0; k < n; k++) w[k*8 +: 8] = px[k];
        if (sec_b) begin
            if_b.pencere_i = w[23:0]; if_b.mod_i = m; if_b.giris_gecerli_i = 1'b1;
        end else begin
            if_a.pencere_i = w; if_a.mod_i = m; if_a.giris_gecerli_i = 1'b1;
        end
        bekleme = 0;
        bitti = 1'b0;
        while (!bitti) begin
            @(negedge clk);
            if (sec_b ? if_b.giris_hazir_o : if_a.giris_hazir_o) begin
                if (sec_b) exp_q_b.push_back(ref_model(px, n, m));
                else       exp_q_a.push_back(ref_model(px, n, m));
                son_kabul = cyc + 1;
                bitti = 1'b1;
            end else begin
                bekleme++;
                if (bekleme > 200) begin
                    check(1'b0, "kabul_zaman_asimi", bekleme, 200);
                    bitti = 1'b1;
                end
            end
        end
        adim();
        if (sec_b) if_b.giris_gecerli_i = 1'b0;
        else       if_a.giris_gecerli_i = 1'b0;
    endtask

    task automatic wait_bos();
        int t;
        t = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(exp_q_a.size() == 0 && exp_q_b.size() == 0, "bosalma",
              exp_q_a.size() + exp_q_b.size(), 0);
        adim();
    endtask

    // scoreboard monitors
    initial begin : mon_a
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                if (if_a.cikis_gecerli_o) begin
                    if (if_a.cikis_hazir_i) begin
                        if (exp_q_a.size() == 0) check(1'b0, "a_beklenmeyen_cikis", if_a.pixel_o, -1);
                        else begin
                            e = exp_q_a.pop_front();
                            check(if_a.pixel_o == e, "a_pixel", if_a.pixel_o, e);
                        end
                    end
                end else begin
                    check(if_a.pixel_o == 8'd0, "a_bos_pixel", if_a.pixel_o, 0);
                end
            end
        end
    end

    initial begin : mon_b
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                if (if_b.cikis_gecerli_o) begin
                    if (if_b.cikis_hazir_i) begin
                        if (exp_q_b.size() == 0) check(1'b0, "b_beklenmeyen_cikis", if_b.pixel_o, -1);
                        else begin
                            e = exp_q_b.pop_front();
                            check(if_b.pixel_o == e, "b_pixel", if_b.pixel_o, e);
                        end
                    end
                end else begin
                    check(if_b.pixel_o == 8'd0, "b_bos_pixel", if_b.pixel_o, 0);
                end
            end
        end
    end

    // stimulus
    initial begin : ana
        pen_t p;
        pen_t p42;
        int bk, ilk, t;
        rstn = 1'b0;
        temizle = 1'b0;
        if_a.giris_gecerli_i = 1'b0; if_a.pencere_i = '0; if_a.mod_i = 2'b00; if_a.cikis_hazir_i = 1'b1;
        if_b.giris_gecerli_i = 1'b0; if_b.pencere_i = '0; if_b.mod_i = 2'b00; if_b.cikis_hazir_i = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check(if_a.giris_hazir_o == 1'b1, "rst_a_hazir", if_a.giris_hazir_o, 1);
        check(if_a.cikis_gecerli_o == 1'b0, "rst_a_gecerli", if_a.cikis_gecerli_o, 0);
        check(if_a.pixel_o == 8'd0, "rst_a_pixel", if_a.pixel_o, 0);
        check(dol_a == 4'd0, "rst_a_doluluk", dol_a, 0);
        check(dbg_a == '0, "rst_a_durum", dbg_a, 0);
        check(if_b.giris_hazir_o == 1'b1, "rst_b_hazir", if_b.giris_hazir_o, 1);
        check(dol_b == 3'd0, "rst_b_doluluk", dol_b, 0);
        adim();
        rstn = 1'b1;
        adim();

        // median / min / max of one window, back to back; first-result latency
        p = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        push_win(1'b0, p, 2'b00, bk);
        ilk = son_kabul;
        push_win(1'b0, p, 2'b01, bk);
        push_win(1'b0, p, 2'b10, bk);
        t = 0;
        while (!if_a.cikis_gecerli_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(cyc - ilk == 9, "ilk_gecikme", cyc - ilk, 9);
        wait_bos();

        // duplicates
        p = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        push_win(1'b0, p, 2'b00, bk);
        p = '{8'd3, 8'd3, 8'd3, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
        push_win(1'b0, p, 2'b00, bk);
        push_win(1'b0, p, 2'b11, bk);
        push_win(1'b0, p, 2'b10, bk);
        wait_bos();

        // back-pressure: fill the pool, hold off an 11th window, then release
        if_a.cikis_hazir_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rastgele(p);
            push_win(1'b0, p, 2'($urandom_range(0, 3)), bk);
        end
        @(negedge clk);
        check(dol_a == 4'd10, "dolu_doluluk", dol_a, 10);
        check(if_a.giris_hazir_o == 1'b0, "dolu_hazir", if_a.giris_hazir_o, 0);
        adim();
        rastgele(p);
        fork
            push_win(1'b0, p, 2'b00, bk);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check(if_a.giris_hazir_o == 1'b0, "tutma_hazir", if_a.giris_hazir_o, 0);
                    check(dol_a == 4'd10, "tutma_doluluk", dol_a, 10);
                    check(if_a.cikis_gecerli_o == 1'b1, "tutma_gecerli", if_a.cikis_gecerli_o, 1);
                    check(if_a.pixel_o == exp_q_a[0], "tutma_pixel", if_a.pixel_o, exp_q_a[0]);
                end
                adim();
                if_a.cikis_hazir_i = 1'b1;
            end
        join
        wait_bos();

        // sustained streaming: one window and one result per cycle
        fork
            for (int i = 0; i < 40; i++) begin
                rastgele(p);
                push_win(1'b0, p, 2'($urandom_range(0, 3)), bk);
                check(bk == 0, "akis_bekleme", bk, 0);
            end
            begin
                repeat (12) @(negedge clk);
                repeat (25) begin
                    @(negedge clk);
                    check(dol_a == 4'd10, "akis_doluluk", dol_a, 10);
                    check(if_a.giris_hazir_o == 1'b1, "akis_hazir", if_a.giris_hazir_o, 1);
                    check(if_a.cikis_gecerli_o == 1'b1, "akis_gecerli", if_a.cikis_gecerli_o, 1);
                end
            end
        join
        wait_bos();

        // flush with windows in flight
        for (int i = 0; i < 4; i++) begin
            rastgele(p);
            push_win(1'b0, p, 2'b00, bk);
        end
        temizle = 1'b1;
        @(negedge clk);
        check(if_a.giris_hazir_o == 1'b0, "temizle_hazir", if_a.giris_hazir_o, 0);
        check(if_a.cikis_gecerli_o == 1'b0, "temizle_gecerli", if_a.cikis_gecerli_o, 0);
        exp_q_a.delete();
        adim();
        temizle = 1'b0;
        @(negedge clk);
        check(dol_a == 4'd0, "temizle_doluluk", dol_a, 0);
        check(dbg_a == '0, "temizle_durum", dbg_a, 0);
        repeat (12) begin
            @(negedge clk);
            check(if_a.cikis_gecerli_o == 1'b0, "temizle_bayat", if_a.cikis_gecerli_o, 0);
        end
        adim();
        p42 = '{8'd50, 8'd10, 8'd42, 8'd99, 8'd3, 8'd77, 8'd41, 8'd200, 8'd1};
        push_win(1'b0, p42, 2'b00, bk);
        wait_bos();

        // asynchronous reset with one result held and one lane computing
        if_a.cikis_hazir_i = 1'b0;
        rastgele(p); push_win(1'b0, p, 2'b00, bk);
        rastgele(p); push_win(1'b0, p, 2'b01, bk);
        repeat (10) adim();
        rastgele(p); push_win(1'b0, p, 2'b10, bk);
        repeat (2) adim();
        check(if_a.cikis_gecerli_o == 1'b1, "onrst_gecerli", if_a.cikis_gecerli_o, 1);
        check(dol_a == 4'd3, "onrst_doluluk", dol_a, 3);
        #2;
        rstn = 1'b0;
        #1;
        check(if_a.cikis_gecerli_o == 1'b0, "arst_gecerli", if_a.cikis_gecerli_o, 0);
        check(if_a.pixel_o == 8'd0, "arst_pixel", if_a.pixel_o, 0);
        check(dol_a == 4'd0, "arst_doluluk", dol_a, 0);
        check(if_a.giris_hazir_o == 1'b1, "arst_hazir", if_a.giris_hazir_o, 1);
        check(dbg_a == '0, "arst_durum", dbg_a, 0);
        exp_q_a.delete();
        repeat (2) adim();
        rstn = 1'b1;
        if_a.cikis_hazir_i = 1'b1;
        adim();

        // small pool: pointer wrap over 12 windows with random back-pressure
        fork
            for (int i = 0; i < 12; i++) begin
                rastgele(p);
                push_win(1'b1, p, 2'($urandom_range(0, 3)), bk);
            end
            begin
                repeat (40) begin
                    adim();
                    if_b.cikis_hazir_i = 1'($urandom_range(0, 1));
                end
                if_b.cikis_hazir_i = 1'b1;
            end
        join
        wait_bos();
        check(dol_b == 3'd0, "b_son_doluluk", dol_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end
endmodule
